pwm_audio_out: RTL and testbench
================================

// Module: pwm_audio_out
// PURPOSE
//   Downstream consumer of the triangle/tone generator sample stream. Accepts samples over a
//   valid/ready handshake into a 1-entry pending buffer. Loads each sample into the duty register
//   only at a PWM frame boundary, so the duty cycle never changes mid-frame.
//   Drives a single-bit PWM pin to the board's RC low-pass/speaker.
// PARAMETERS
//   SAMPLE_W    8   sample width; the PWM frame is 2**SAMPLE_W ticks
//   PRESCALE_W  8   width of the runtime prescale input
// PORTS
//   clk           in   1           system clock; single clock domain
//   rst           in   1           synchronous reset, ACTIVE-LOW (rst==0 resets on the clk edge)
//   prescale      in   PRESCALE_W  one PWM tick every prescale+1 clocks; sampled at each tick
//   sample        in   SAMPLE_W    unsigned sample from the tone generator
//   sample_valid  in   1           sample is presented
//   sample_ready  out  1           pending buffer empty; a transfer happens when valid&&ready
//   volume        in   4           present only with PWM_VOLUME_EN
//   pwm_out       out  1           registered PWM output
//   frame_start   out  1           1-clk pulse on the clock where a new frame begins (duty reloaded)
//   underrun      out  1           sticky flag: a frame began with the pending buffer empty
// BEHAVIOUR
//   Reset (rst==0): pwm_out=0, frame_start=0, underrun=0, sample_ready=0, duty=0,
//     pending empty, pwm_ctr=0, tick divider=0. sample_ready=1 from the first clock after release.
//   Tick: the divider counts 0..prescale and emits tick on reaching prescale, then returns to 0.
//     prescale=0 gives a tick every clock. The divider clears to 0 on reaching the terminal count.
//   pwm_ctr: SAMPLE_W bits, increments on tick, wraps from 2**SAMPLE_W-1 to 0.
//   Frame boundary: a tick while pwm_ctr==max. On that clock:
//     - If pending is full: duty<=pending and pending is emptied.
//     - Otherwise: duty holds its previous value and underrun<=1.
//     - frame_start=1 on the same clock.
//   Handshake: sample_ready = !pending_full (registered-state based, not combinational from valid).
//     While pending is full, sample_valid is ignored. A sample may not be dropped.
//   Simultaneous accept and frame boundary (pending empty): the accepted sample goes to pending,
//     not to duty. Duty holds its value and underrun is set. The sample loads at the next boundary.
//   Latency: a sample accepted at clock t drives pwm_out starting with the first frame after the
//     next boundary.
//   pwm_out <= (pwm_ctr < duty), updated every clock.
//     - duty=0: pin constantly low.
//     - duty=max: pin high for 2**SAMPLE_W-1 of 2**SAMPLE_W ticks.
//   underrun clears only on reset.
//   Reset asserted mid-frame: everything returns to reset values on that edge. The pending sample is lost.
// CONFIGURATION
//   PWM_VOLUME_EN defined:
//     - The volume port exists.
//     - At a boundary, duty <= (pending*(volume+1))>>4, computed at full width with no overflow.
//       volume=15 gives unity gain; volume=0 gives pending>>4.
//   PWM_VOLUME_EN undefined:
//     - No volume port and no multiplier.
//     - duty <= pending.
// STRUCTURE
//   sound_pkg: SAMPLE_W default, VOL_W=4, and the VOL_SHIFT=4 constant, shared with the tone generators.
//   Sub-module tick_divider (prescale -> 1-clk tick pulse). The buffer, frame counter and
//   comparator stay inline.
// TESTING
//   1. Release reset with prescale=0 and push 8'h80 -> frame_start every 256 clks. After the next
//      boundary, pwm_out is high for 128 clks per frame; underrun=1 from the first boundary.
//   2. Push 8'h00, then 8'hFF in later frames -> the first frame is all low; the second has
//      255 clks high and 1 clk low.
//   3. Hold sample_valid=1 continuously -> sample_ready drops after 1 accept and rises the clock
//      after each boundary. No sample is skipped; check the order against a scoreboard.
//   4. Accept a sample on the exact boundary clock with pending empty -> duty unchanged,
//      underrun=1, and the sample appears one frame later.
//   5. prescale=3 -> tick every 4 clks and a frame of 1024 clks. Change prescale to 0 mid-frame:
//      the new period takes effect after the current tick.
//   6. PWM_VOLUME_EN: sample=8'hFF with volume=7 -> duty=8'h7F. Assert rst=0 mid-frame ->
//      pwm_out=0 and sample_ready=0 on the next edge.

Source files
------------

// File: rtl/sound_pkg.sv
// -----------------------------------------------------------------------------
// sound_pkg
//   Constants shared by the tone generators and the PWM audio output stage.
//   SAMPLE_W_DEF   default sample width (PWM frame = 2**SAMPLE_W ticks)
//   PRESCALE_W_DEF default width of the runtime prescale value
//   VOL_W          width of the volume control
//   VOL_SHIFT      right shift applied after volume scaling (volume+1 is /16)
// -----------------------------------------------------------------------------
package sound_pkg;
    localparam int SAMPLE_W_DEF   = 8;
    localparam int PRESCALE_W_DEF = 8;
    localparam int VOL_W          = 4;
    localparam int VOL_SHIFT      = 4;
endpackage

// File: rtl/pwm_audio_out_tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Produces a 1-clock tick every prescale+1 clocks.
//   i_clk       system clock
//   i_rst_n     synchronous active-low reset
//   i_prescale  divide value; captured at reset and at every tick, so a change
//               mid-period only takes effect after the tick in progress
//   o_tick      1-clock pulse when the divider reaches its terminal count
// -----------------------------------------------------------------------------
module tick_divider
    import sound_pkg::*;
#(
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);
    logic [PRESCALE_W-1:0] r_div;
    logic [PRESCALE_W-1:0] r_pre;

    // Comparing against a latched copy keeps the count from running past a
    // terminal value that was lowered mid-period.
    assign o_tick = (r_div == r_pre);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_div <= '0;
            r_pre <= i_prescale;
        end else if (o_tick) begin
            r_div <= '0;
            r_pre <= i_prescale;
        end else begin
            r_div <= r_div + PRESCALE_W'(1);
        end
    end
endmodule

// File: rtl/pwm_audio_out.sv
// -----------------------------------------------------------------------------
// pwm_audio_out
//   Accepts samples over valid/ready into a 1-entry pending buffer and loads
//   them into the duty register only at a PWM frame boundary.
//   clk           system clock
//   rst           synchronous active-low reset
//   prescale      one PWM tick every prescale+1 clocks
//   sample        unsigned input sample
//   sample_valid  sample presented
//   sample_ready  pending buffer empty (registered state only)
//   volume        gain control, present only when PWM_VOLUME_EN is defined
//   pwm_out       registered PWM pin
//   frame_start   1-clock pulse on the clock where the new duty takes effect
//   underrun      sticky: a frame began with nothing pending
// Build option: PWM_VOLUME_EN enables the volume port and the gain multiply.
// -----------------------------------------------------------------------------
module pwm_audio_out
    import sound_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEF,
    parameter int PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [SAMPLE_W-1:0]   sample,
    input  logic                  sample_valid,
    output logic                  sample_ready,
`ifdef PWM_VOLUME_EN
    input  logic [VOL_W-1:0]      volume,
`endif
    output logic                  pwm_out,
    output logic                  frame_start,
    output logic                  underrun
);
    logic                w_tick;
    logic                w_bnd;
    logic                w_accept;
    logic [SAMPLE_W-1:0] w_load;

    logic [SAMPLE_W-1:0] r_ctr;
    logic [SAMPLE_W-1:0] r_duty;
    logic [SAMPLE_W-1:0] r_pend;
    logic                r_full;
    logic                r_alive;
    logic                r_pwm;
    logic                r_fs;
    logic                r_unr;

    tick_divider #(.PRESCALE_W(PRESCALE_W)) u_div (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_prescale (prescale),
        .o_tick     (w_tick)
    );

    assign w_bnd        = w_tick && (r_ctr == '1);
    // r_alive holds ready low through reset and for the release edge itself.
    assign sample_ready = r_alive && !r_full;
    assign w_accept     = sample_valid && sample_ready;

`ifdef PWM_VOLUME_EN
    localparam int PW = SAMPLE_W + VOL_W + 1;
    logic [VOL_W:0] w_gain;
    logic [PW-1:0]  w_prod;
    assign w_gain = {1'b0, volume} + (VOL_W + 1)'(1);
    // Full-width product; after the shift the result always fits SAMPLE_W.
    assign w_prod = PW'(r_pend) * PW'(w_gain);
    assign w_load = SAMPLE_W'(w_prod >> VOL_SHIFT);
`else
    assign w_load = r_pend;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ctr   <= '0;
            r_duty  <= '0;
            r_pend  <= '0;
            r_full  <= 1'b0;
            r_alive <= 1'b0;
            r_pwm   <= 1'b0;
            r_fs    <= 1'b0;
            r_unr   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_fs    <= w_bnd;
            r_pwm   <= (r_ctr < r_duty);
            if (w_tick)
                r_ctr <= r_ctr + SAMPLE_W'(1);
            if (w_bnd) begin
                if (r_full) begin
                    r_duty <= w_load;
                    r_full <= 1'b0;
                end else begin
                    r_unr  <= 1'b1;
                end
            end
            // Accept needs an empty buffer, so it never collides with the
            // boundary drain above; a sample landing on the boundary waits
            // in pending for the next one.
            if (w_accept) begin
                r_pend <= sample;
                r_full <= 1'b1;
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign frame_start = r_fs;
    assign underrun    = r_unr;
endmodule

// File: tb/tb_pwm_audio_out.sv
module tb_pwm_audio_out;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] prescale = 8'd0;
    logic [7:0] sample = 8'd0;
    logic       sample_valid = 1'b0;
    logic [3:0] volume = 4'd15;
    logic       sample_ready, pwm_out, frame_start, underrun;

    always #5 clk = ~clk;

    pwm_audio_out dut (
        .clk          (clk),
        .rst          (rst),
        .prescale     (prescale),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
`ifdef PWM_VOLUME_EN
        .volume       (volume),
`endif
        .pwm_out      (pwm_out),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: tick times as absolute clock numbers, frame position as
    // a tick count mod 256, pending buffer as a queue.
    int m_n = 0, m_next = 0, m_pos = 0, m_duty = 0;
    int m_q[$];
    bit m_alive = 0, m_unr = 0, m_fs = 0, m_acc = 0, m_hold = 0;
    int e_pwm = 0;
    int sb[$];
    int len, hi, d_prev, x_val, v;

    function automatic int scale(int s);
`ifdef PWM_VOLUME_EN
        return (s * (int'(volume) + 1)) / 16;
`else
        return s;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        logic rst_now;
        bit   tick, bnd;
        rst_now = rst;
        tick  = (m_n == m_next);
        bnd   = tick && (m_pos == 255);
        m_acc = rst_now && sample_valid && m_alive && (m_q.size() == 0);
        e_pwm = (m_pos < m_duty) ? 1 : 0;
        @(posedge clk);
        #1;
        if (!rst_now) begin
            m_n = 0; m_next = int'(prescale); m_pos = 0; m_duty = 0;
            m_q.delete(); m_alive = 0; m_unr = 0; m_fs = 0; e_pwm = 0;
        end else begin
            if (bnd) begin
                if (m_q.size() != 0) m_duty = scale(m_q.pop_front());
                else m_unr = 1;
            end
            if (m_acc) begin
                m_q.push_back(int'(sample));
                if (m_hold) sb.push_back(int'(sample));
            end
            if (tick) begin
                m_pos  = (m_pos + 1) % 256;
                m_next = m_n + int'(prescale) + 1;
            end
            m_fs = bnd;
            m_alive = 1;
            m_n++;
        end
        chk("pwm_out", pwm_out, e_pwm);
        chk("frame_start", frame_start, m_fs);
        chk("underrun", underrun, m_unr);
        chk("sample_ready", sample_ready, (m_alive && m_q.size() == 0) ? 1 : 0);
        if (m_hold && m_acc) sample = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_fs();
        for (int i = 0; i < 5000; i++) begin
            step();
            if (frame_start === 1'b1) return;
        end
        chk("wait_fs_timeout", 0, 1);
    endtask

    task automatic count_frame(output int l, output int h);
        l = 0; h = 0;
        do begin
            step();
            l++;
            h += (pwm_out === 1'b1) ? 1 : 0;
        end while (frame_start !== 1'b1 && l < 5000);
        if (l >= 5000) chk("count_frame_timeout", 0, 1);
    endtask

    task automatic push(input logic [7:0] s);
        sample = s;
        sample_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (m_acc) begin
                sample_valid = 1'b0;
                return;
            end
        end
        sample_valid = 1'b0;
        chk("push_timeout", 0, 1);
    endtask

    initial begin
        // reset state
        repeat (3) step();
        rst = 1'b1;

        // first boundary with nothing pending
        wait_fs();
        chk("underrun_first_bnd", underrun, 1);

        // 0x80 -> 128 of 256
        push(8'h80);
        wait_fs();
        count_frame(len, hi);
        chk("frame_len_p0", len, 256);
        chk("high_0x80", hi, 128);

        // extremes
        push(8'h00);
        wait_fs();
        count_frame(len, hi);
        chk("high_0x00", hi, 0);
        push(8'hFF);
        wait_fs();
        count_frame(len, hi);
        chk("high_0xFF", hi, 255);

        // random values
        for (int k = 0; k < 2; k++) begin
            v = $urandom_range(0, 255);
            push(8'(v));
            wait_fs();
            count_frame(len, hi);
            chk("high_rand", hi, v);
        end

        // valid held high: order preserved, nothing skipped
        sb.delete();
        m_hold = 1;
        sample = 8'($urandom_range(0, 255));
        sample_valid = 1'b1;
        wait_fs();
        for (int k = 0; k < 5; k++) begin
            count_frame(len, hi);
            chk("sb_order", hi, (sb.size() != 0) ? sb.pop_front() : -1);
        end
        sample_valid = 1'b0;
        m_hold = 0;

        // accept exactly on the boundary clock
        d_prev = m_duty;
        do x_val = $urandom_range(1, 254); while (x_val == d_prev);
        for (int i = 0; i < 2000 && !(m_pos == 255 && m_n == m_next); i++) step();
        sample = 8'(x_val);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("bnd_acc_fs", frame_start, 1);
        chk("bnd_acc_underrun", underrun, 1);
        chk("bnd_acc_ready", sample_ready, 0);
        count_frame(len, hi);
        chk("bnd_acc_duty_held", hi, d_prev);
        count_frame(len, hi);
        chk("bnd_acc_loaded_late", hi, x_val);

        // prescale=3: first tick still on the old period
        prescale = 8'd3;
        count_frame(len, hi);
        chk("frame_len_transition", len, 1021);
        count_frame(len, hi);
        chk("frame_len_p3", len, 1024);
        chk("high_p3", hi, 4 * x_val);
        repeat (101) step();
        prescale = 8'd0;
        count_frame(len, hi);
        count_frame(len, hi);
        chk("frame_len_back_p0", len, 256);
        chk("high_back_p0", hi, x_val);

`ifdef PWM_VOLUME_EN
        volume = 4'd7;
        push(8'hFF);
        wait_fs();
        count_frame(len, hi);
        chk("vol7_high", hi, 127);
`endif

        // reset mid-frame
        repeat (40) step();
        rst = 1'b0;
        step();
        chk("midrst_pwm", pwm_out, 0);
        chk("midrst_ready", sample_ready, 0);
        chk("midrst_underrun", underrun, 0);
        step();
        rst = 1'b1;
        wait_fs();
        count_frame(len, hi);
        chk("post_rst_len", len, 256);
        chk("post_rst_high", hi, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
